// File: rtl/mmt_ser_pkg.sv
// Shared types and constants for the matrix-multiply output serializer.
// Optional CRC trailer is enabled by defining MMT_SER_CRC_EN.
package mmt_ser_pkg;

    localparam int WORD_W         = 50;
    localparam int BYTES_PER_WORD = 7;
    localparam int CNT_W          = 8;
    localparam int SHIFT_W        = BYTES_PER_WORD * 8;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
        logic [CNT_W-1:0]  count;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CNT  = 2'd2,
        ST_CRC  = 2'd3
    } ser_state_t;

    // One byte of CRC-8, MSB-first, no reflection.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/mmt_ser_fifo.sv
// Synchronous word FIFO with full/empty/level; a push while full only lands
// when a pop happens in the same cycle.
module mmt_ser_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 59
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level/pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mmt_out_serializer.sv
// Captures non-stallable result bursts, buffers them and emits framed bytes
// (7 data bytes per word, count trailer, CRC byte when MMT_SER_CRC_EN is defined).
module mmt_out_serializer
    import mmt_ser_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   out_valid,
    input  logic [49:0]            out_value,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_last,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] fifo_level
);

    logic [WORD_W-1:0]  hold_q, hold_d;
    logic               hold_v_q, hold_v_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    ser_state_t         state_q, state_d;
    logic [SHIFT_W-1:0] sh_q, sh_d;
    logic [2:0]         idx_q, idx_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push, pop, fifo_full, fifo_empty, hs;
    fifo_entry_t        push_entry, rd_entry;
    logic [ENTRY_W-1:0] fifo_rdata;

    mmt_ser_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign rd_entry = fifo_entry_t'(fifo_rdata);
    assign tx_valid = (state_q != ST_IDLE);
    assign hs       = tx_valid && tx_ready;
    assign ovf      = ovf_q;

    // Hold stage delays each word by one cycle so the frame's final word is
    // known when out_valid drops.
    always_comb begin
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_entry = '0;
        if (out_valid) begin
            hold_d   = out_value;
            hold_v_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 8'd1;
            if (hold_v_q) begin
                push            = 1'b1;
                push_entry.data = hold_q;
            end
        end else if (hold_v_q) begin
            push             = 1'b1;
            push_entry.data  = hold_q;
            push_entry.last  = 1'b1;
            push_entry.count = cnt_q;
            hold_v_d         = 1'b0;
            cnt_d            = '0;
        end
        ovf_d = ovf_q | (push && fifo_full && !pop);
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        last_d  = last_q;
        count_d = count_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = {6'b0, rd_entry.data};
                    idx_d   = '0;
                    last_d  = rd_entry.last;
                    count_d = rd_entry.count;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hs) begin
                    if (idx_q == 3'd6) begin
                        if (last_q) begin
                            state_d = ST_CNT;
                        end else if (!fifo_empty) begin
                            // Back-to-back entry of the same frame: no IDLE bubble.
                            pop     = 1'b1;
                            sh_d    = {6'b0, rd_entry.data};
                            idx_d   = '0;
                            last_d  = rd_entry.last;
                            count_d = rd_entry.count;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sh_d  = sh_q >> 8;
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_CNT: begin
`ifdef MMT_SER_CRC_EN
                if (hs) state_d = ST_CRC;
`else
                if (hs) state_d = ST_IDLE;
`endif
            end
            default: begin
                if (hs) state_d = ST_IDLE;
            end
        endcase
    end

`ifdef MMT_SER_CRC_EN
    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (hs && (state_q == ST_DATA || state_q == ST_CNT)) crc_d = crc8_update(crc_q, tx_data);
        else if (hs && state_q == ST_CRC)                   crc_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign tx_last = (state_q == ST_CRC);
`else
    assign tx_last = (state_q == ST_CNT);
`endif

    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            ST_DATA: tx_data = sh_q[7:0];
            ST_CNT:  tx_data = count_q;
`ifdef MMT_SER_CRC_EN
            ST_CRC:  tx_data = crc_q;
`endif
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            sh_q     <= sh_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_mmt_out_serializer.sv
// Directed bench for mmt_out_serializer; follows MMT_SER_CRC_EN for the CRC trailer.
module tb_mmt_out_serializer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_valid = 1'b0;
    logic [49:0] out_value = '0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        ovf;
    logic [4:0]  fifo_level;

    int vectors = 0;
    int miscompares = 0;
    int ready_mode = 0;
    int stall_errs = 0;

    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    logic [49:0] frame_q[$];
    logic [7:0]  exp_crc = 8'h00;
    logic        stall_prev = 1'b0;
    logic [8:0]  stall_val = '0;

    mmt_out_serializer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .out_valid  (out_valid),
        .out_value  (out_value),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .ovf        (ovf),
        .fifo_level (fifo_level)
    );

    // clock / ready pattern
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
        endcase
    end

    // byte monitor: records handshakes and flags unstable stalled bytes
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && !(tx_valid && {tx_last, tx_data} == stall_val)) stall_errs++;
            if (tx_valid && tx_ready) got_q.push_back({tx_last, tx_data});
            stall_prev = tx_valid && !tx_ready;
            stall_val  = {tx_last, tx_data};
        end
    end

    function automatic logic [7:0] tb_crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    // driver tasks
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) begin
            out_valid = 1'b1;
            out_value = frame_q[i];
            tick();
        end
        out_valid = 1'b0;
        out_value = '0;
        tick();
    endtask

    task automatic wait_bytes(input int n);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < 4000) begin
            @(negedge clk);
            #1;
            guard++;
        end
    endtask

    // expected-stream builders
    task automatic expect_word(input logic [49:0] w);
        logic [55:0] v;
        v = {6'b0, w};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({1'b0, v[8*i +: 8]});
            exp_crc = tb_crc8(exp_crc, v[8*i +: 8]);
        end
    endtask

    task automatic expect_trailer(input logic [7:0] cnt);
`ifdef MMT_SER_CRC_EN
        exp_q.push_back({1'b0, cnt});
        exp_crc = tb_crc8(exp_crc, cnt);
        exp_q.push_back({1'b1, exp_crc});
`else
        exp_q.push_back({1'b1, cnt});
`endif
        exp_crc = 8'h00;
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        vectors++;
        if ({tx_valid, tx_data, tx_last, ovf, fifo_level} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b ovf=%b lvl=%0d, expected all zero",
                     tx_valid, tx_data, tx_last, ovf, fifo_level);
        end
        rst = 1'b0;
        tick(3);
        vectors++;
        if (tx_valid !== 1'b0 || fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got v=%b lvl=%0d, expected 0/0", tx_valid, fifo_level);
        end
    endtask

    task automatic test_one_word();
        got_q.delete();
        exp_q.delete();
`ifdef MMT_SER_CRC_EN
        out_value = 50'h0;
        exp_q = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h001, 9'h107};
`else
        out_value = 50'h00000000000AB;
        exp_q = '{9'h0AB, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h101};
`endif
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        out_value = '0;
        tick();
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_cycle2: got tx_valid=%b, expected 0", tx_valid);
        end
        tick();
        vectors++;
        if (tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_cycle3: got tx_valid=%b, expected 1", tx_valid);
        end
        wait_bytes(exp_q.size());
        tick(10);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL one_word_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL one_word_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_max_word();
        got_q.delete();
        exp_q.delete();
        frame_q = '{50'h3FFFFFFFFFFFF};
        expect_word(50'h3FFFFFFFFFFFF);
        expect_trailer(8'h01);
        send_frame();
        wait_bytes(exp_q.size());
        tick(10);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL max_word_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL max_word_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (got_q.size() > 6 && got_q[6] !== 9'h003) begin
            miscompares++;
            $display("FAIL max_word_top: got %h, expected 003", got_q[6]);
        end
    endtask

    task automatic test_ready_toggle();
        got_q.delete();
        exp_q.delete();
        stall_errs = 0;
        ready_mode = 1;
        frame_q.delete();
        for (int k = 0; k < 16; k++) begin
            frame_q.push_back(50'h1_2345_6789_ABCD + 50'(k) * 50'h0_0101_0101_0101);
            expect_word(frame_q[k]);
        end
        expect_trailer(8'h10);
        send_frame();
        wait_bytes(exp_q.size());
        tick(4);
        frame_q.delete();
        for (int k = 0; k < 4; k++) begin
            frame_q.push_back(50'h2_A5A5_0F0F_3C3C ^ (50'(k) << 44));
            expect_word(frame_q[k]);
        end
        expect_trailer(8'h04);
        send_frame();
        wait_bytes(exp_q.size());
        tick(10);
        ready_mode = 0;
        tick(2);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL toggle_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL toggle_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (stall_errs != 0) begin
            miscompares++;
            $display("FAIL toggle_stall_stable: got %0d unstable stalls, expected 0", stall_errs);
        end
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_no_ovf: got ovf=%b, expected 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        exp_q.delete();
        frame_q = '{50'h0_0000_1234_5678};
        expect_word(frame_q[0]);
        expect_trailer(8'h01);
        send_frame();
        frame_q = '{50'h1_0203_0405_0607, 50'h3_F0E0_D0C0_B0A0};
        expect_word(frame_q[0]);
        expect_word(frame_q[1]);
        expect_trailer(8'h02);
        send_frame();
        wait_bytes(exp_q.size());
        tick(10);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int max_level;
        got_q.delete();
        exp_q.delete();
        stall_errs = 0;
        ready_mode = 2;
        tick();
        frame_q.delete();
        for (int k = 0; k < 20; k++) frame_q.push_back(50'h0_0C0D_E000_0000 + 50'(k));
        // word 0 sits in the shifter, words 1..16 fill the FIFO, 17..19 are dropped
        for (int k = 0; k < 17; k++) expect_word(frame_q[k]);
        send_frame();
        tick(3);
        max_level = int'(fifo_level);
        vectors++;
        if (fifo_level !== 5'd16) begin
            miscompares++;
            $display("FAIL ovf_level: got %0d, expected 16", fifo_level);
        end
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag: got %b, expected 1", ovf);
        end
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++;
            $display("FAIL ovf_no_bytes_while_stalled: got %0d bytes, expected 0", got_q.size());
        end
        ready_mode = 0;
        wait_bytes(exp_q.size());
        tick(20);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL ovf_drain_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ovf_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (fifo_level !== 5'd0 || ovf !== 1'b1 || stall_errs != 0) begin
            miscompares++;
            $display("FAIL ovf_after: got lvl=%0d ovf=%b stalls=%0d (peak %0d), expected 0/1/0",
                     fifo_level, ovf, stall_errs, max_level);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        got_q.delete();
        exp_q.delete();
        frame_q = '{50'h0_1122_3344_5566, 50'h0_7788_99AA_BBCC};
        send_frame();
        guard = 0;
        while (got_q.size() < 2 && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
        end
        vectors++;
        if (got_q.size() != 2 || tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_setup: got %0d bytes v=%b, expected 2 bytes v=1", got_q.size(), tx_valid);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({tx_valid, tx_data, tx_last, ovf, fifo_level} !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got v=%b d=%h l=%b ovf=%b lvl=%0d, expected all zero",
                     tx_valid, tx_data, tx_last, ovf, fifo_level);
        end
        rst = 1'b0;
        got_q.delete();
        tick(10);
        vectors++;
        if (got_q.size() != 0 || fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: got %0d bytes lvl=%0d, expected 0/0", got_q.size(), fifo_level);
        end
        frame_q = '{50'h2_0000_0000_005A};
        exp_crc = 8'h00;
        expect_word(frame_q[0]);
        expect_trailer(8'h01);
        send_frame();
        wait_bytes(exp_q.size());
        tick(10);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rst_after_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rst_after_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_word();
        test_max_word();
        test_ready_toggle();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
